// File: rtl/cpcs_pkg.sv
// Shared encodings and width helpers for the CorePCS word-sync controller.
// Pure declarations: no latency, no flow control.
package cpcs_pkg;

    typedef enum logic [1:0] {
        ST_LOS  = 2'b00,
        ST_ACQ  = 2'b01,
        ST_SYNC = 2'b10
    } cpcs_state_t;

    localparam int ACQ_TMR_W = 16;
    localparam int ERR_CNT_W = 16;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cpcs_sat_cnt.sv
// Generic saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module cpcs_sat_cnt #(
    parameter int W = 16
) (
    input  logic         core_clk,
    input  logic         aresetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge core_clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpcs_word_sync_ctrl.sv
// 8b/10b receive word-sync FSM: qualifies commas by word parity, sequences LOS/ACQ/SYNC.
// Latency: every output is registered, one cycle after the sampled word.
// Backpressure: none; RX_EN low freezes state, counters and parity.
module cpcs_word_sync_ctrl
    import cpcs_pkg::*;
#(
    parameter int PROG_COMMA_EN = 0,
    parameter int N_ACQ         = 3,
    parameter int N_LOSS        = 4,
    parameter int N_GOOD        = 4,
    parameter int ACQ_TIMEOUT   = 255
) (
    input  logic                 RBC1,
    input  logic                 RSTN,
    input  logic                 RX_EN,
    input  logic                 COMMA_DETECT,
    input  logic                 CODE_ERROR,
    input  logic                 CNT_CLR,
    output logic                 WORD_SYNC_L,
    output logic                 COMMA_DETECT_ENABLE,
    output logic                 SYNC_LOST,
    output logic [1:0]           STATE,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int AW = cnt_w(N_ACQ);
    localparam int BW = cnt_w(N_LOSS);
    localparam int GW = cnt_w(N_GOOD);

    localparam logic [AW-1:0]        ACQ_MAX  = AW'(N_ACQ);
    localparam logic [BW-1:0]        LOSS_MAX = BW'(N_LOSS);
    localparam logic [GW-1:0]        GOOD_MAX = GW'(N_GOOD);
    localparam logic [ACQ_TMR_W-1:0] TMO_MAX  = ACQ_TMR_W'(ACQ_TIMEOUT);

    cpcs_state_t          state_q, state_d;
    logic                 parity_q, parity_d;   // 1 = current word is odd
    logic [AW-1:0]        acq_q, acq_d, acq_inc;
    logic [ACQ_TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
    logic [BW-1:0]        bad_q, bad_d, bad_inc;
    logic [GW-1:0]        good_q, good_d, good_inc;
    logic                 wsl_q, lost_q, lost_d;
    logic                 bad_word, err_inc;

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        acq_d    = acq_q;
        tmr_d    = tmr_q;
        bad_d    = bad_q;
        good_d   = good_q;
        lost_d   = 1'b0;
        err_inc  = 1'b0;
        bad_word = CODE_ERROR | (COMMA_DETECT & parity_q);
        acq_inc  = acq_q + AW'(1);
        tmr_inc  = tmr_q + ACQ_TMR_W'(1);
        bad_inc  = bad_q + BW'(1);
        good_inc = good_q + GW'(1);

        if (RX_EN) begin
            parity_d = ~parity_q;
            case (state_q)
                ST_LOS: begin
                    // Any clean comma re-anchors parity so the next word is odd.
                    if (COMMA_DETECT && !CODE_ERROR) begin
                        parity_d = 1'b1;
                        acq_d    = AW'(1);
                        tmr_d    = '0;
                        if (ACQ_MAX == AW'(1)) begin
                            state_d = ST_SYNC;
                            bad_d   = '0;
                            good_d  = '0;
                        end else begin
                            state_d = ST_ACQ;
                        end
                    end
                end
                ST_ACQ: begin
                    if (bad_word) begin
                        state_d = ST_LOS;
                    end else if (COMMA_DETECT) begin
                        acq_d = acq_inc;
                        tmr_d = '0;
                        if (acq_inc == ACQ_MAX) begin
                            state_d = ST_SYNC;
                            bad_d   = '0;
                            good_d  = '0;
                        end
                    end else begin
                        tmr_d = tmr_inc;
                        if (tmr_inc == TMO_MAX) begin
                            state_d = ST_LOS;
                        end
                    end
                end
                ST_SYNC: begin
                    if (bad_word) begin
                        err_inc = 1'b1;
                        bad_d   = bad_inc;
                        good_d  = '0;
                        if (bad_inc == LOSS_MAX) begin
                            state_d = ST_LOS;
                            lost_d  = 1'b1;
                        end
                    end else if (bad_q != '0) begin
                        // A full run of good words retires one outstanding bad word.
                        if (good_inc == GOOD_MAX) begin
                            bad_d  = bad_q - BW'(1);
                            good_d = '0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end
    end

    always_ff @(posedge RBC1 or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_LOS;
            parity_q <= 1'b0;
            acq_q    <= '0;
            tmr_q    <= '0;
            bad_q    <= '0;
            good_q   <= '0;
            wsl_q    <= 1'b1;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            acq_q    <= acq_d;
            tmr_q    <= tmr_d;
            bad_q    <= bad_d;
            good_q   <= good_d;
            wsl_q    <= (state_d != ST_SYNC);
            lost_q   <= lost_d;
        end
    end

    cpcs_sat_cnt #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .core_clk(RBC1),
        .aresetn (RSTN),
        .clr     (CNT_CLR),
        .inc     (err_inc),
        .cnt     (ERR_CNT)
    );

    assign STATE               = state_q;
    assign WORD_SYNC_L         = wsl_q;
    assign SYNC_LOST           = lost_q;
    assign COMMA_DETECT_ENABLE = (PROG_COMMA_EN != 0) ? wsl_q : 1'b1;

endmodule
